// File: rtl/writeback_register_file_pkg.sv
// rtl/writeback_register_file_pkg.sv - pipeline constants shared by the writeback stage
package writeback_register_file_pkg;

    // Architectural register indices with a fixed role
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_GP   = 5'd28;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Default reset values of the stack and global pointers
    localparam logic [31:0] SP_INIT_DEFAULT = 32'h7FFF_EFFC;
    localparam logic [31:0] GP_INIT_DEFAULT = 32'h1000_8000;

    // Writeback source encoding
    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'b00,
        WB_SEL_MEM = 2'b01,
        WB_SEL_PC  = 2'b10
    } wb_sel_e;

    // PC+4 (link) overrides the ALU/memory choice
    function automatic wb_sel_e wb_sel_decode(input logic alu_mem_or_pc, input logic alu_or_mem);
        if (alu_mem_or_pc) begin
            return WB_SEL_PC;
        end else if (alu_or_mem) begin
            return WB_SEL_MEM;
        end
        return WB_SEL_ALU;
    endfunction

endpackage

// File: rtl/writeback_register_file_writeback_mux.sv
// rtl/writeback_register_file_writeback_mux.sv - 3:1 writeback source select
module writeback_mux
    import writeback_register_file_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_pc_4,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  wb_sel_e               i_sel,
    output logic [DATA_WIDTH-1:0] o_data
);

    // Only the selected source reaches the output, so X on an idle source is masked
    always_comb begin
        o_data = i_alu_result;
        case (i_sel)
            WB_SEL_PC:  o_data = i_pc_4;
            WB_SEL_MEM: o_data = i_mem_data;
            default:    o_data = i_alu_result;
        endcase
    end

endmodule

// File: rtl/writeback_register_file.sv
// rtl/writeback_register_file.sv - writeback select, 32x32 register file with bypass and commit counter
module writeback_register_file
    import writeback_register_file_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_REGS   = 32,
    parameter logic [31:0] SP_INIT    = SP_INIT_DEFAULT,
    parameter logic [31:0] GP_INIT    = GP_INIT_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       in_PC_4,
    input  logic [DATA_WIDTH-1:0]       in_MemoryData,
    input  logic [DATA_WIDTH-1:0]       in_ALUResult,
    input  logic [$clog2(NUM_REGS)-1:0] in_WriteRegister,
    input  logic                        in_CtrlRegWrite,
    input  logic                        in_CtrlALUOrMem,
    input  logic                        in_CtrlALUMemOrPC,
    input  logic [$clog2(NUM_REGS)-1:0] in_ReadRegister1,
    input  logic [$clog2(NUM_REGS)-1:0] in_ReadRegister2,
    output logic [DATA_WIDTH-1:0]       out_ReadData1,
    output logic [DATA_WIDTH-1:0]       out_ReadData2,
    output logic [DATA_WIDTH-1:0]       out_WriteBackData,
    output logic [31:0]                 out_CommitCount
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [31:0]           r_commit_count;
    logic                  w_commit;
    wb_sel_e               w_sel;

    assign w_sel = wb_sel_decode(in_CtrlALUMemOrPC, in_CtrlALUOrMem);

    writeback_mux #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_writeback_mux (
        .i_pc_4       (in_PC_4),
        .i_mem_data   (in_MemoryData),
        .i_alu_result (in_ALUResult),
        .i_sel        (w_sel),
        .o_data       (out_WriteBackData)
    );

    // Writes to $zero are dropped entirely, including from the counter
    assign w_commit = in_CtrlRegWrite && (in_WriteRegister != ADDR_W'(REG_ZERO));

    // Register array: pointer registers get their boot values, the rest clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ADDR_W'(i) == ADDR_W'(REG_GP)) begin
                    r_regs[i] <= DATA_WIDTH'(GP_INIT);
                end else if (ADDR_W'(i) == ADDR_W'(REG_SP)) begin
                    r_regs[i] <= DATA_WIDTH'(SP_INIT);
                end else begin
                    r_regs[i] <= '0;
                end
            end
        end else if (w_commit) begin
            r_regs[in_WriteRegister] <= out_WriteBackData;
        end
    end

    // Retired-write counter, free-running with silent wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_commit_count <= '0;
        end else if (w_commit) begin
            r_commit_count <= r_commit_count + 32'd1;
        end
    end

    assign out_CommitCount = r_commit_count;

    // Read port 1: $zero, then write-through bypass, then array
    always_comb begin
        out_ReadData1 = r_regs[in_ReadRegister1];
        if (in_ReadRegister1 == ADDR_W'(REG_ZERO)) begin
            out_ReadData1 = '0;
        end else if (w_commit && (in_ReadRegister1 == in_WriteRegister)) begin
            out_ReadData1 = out_WriteBackData;
        end
    end

    // Read port 2: same priority as port 1, bypassed independently
    always_comb begin
        out_ReadData2 = r_regs[in_ReadRegister2];
        if (in_ReadRegister2 == ADDR_W'(REG_ZERO)) begin
            out_ReadData2 = '0;
        end else if (w_commit && (in_ReadRegister2 == in_WriteRegister)) begin
            out_ReadData2 = out_WriteBackData;
        end
    end

endmodule

// File: tb/tb_writeback_register_file.sv
// tb/tb_writeback_register_file.sv - directed self-checking bench for writeback_register_file
module tb_writeback_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_PC_4;
    logic [31:0] in_MemoryData;
    logic [31:0] in_ALUResult;
    logic [4:0]  in_WriteRegister;
    logic        in_CtrlRegWrite;
    logic        in_CtrlALUOrMem;
    logic        in_CtrlALUMemOrPC;
    logic [4:0]  in_ReadRegister1;
    logic [4:0]  in_ReadRegister2;
    logic [31:0] out_ReadData1;
    logic [31:0] out_ReadData2;
    logic [31:0] out_WriteBackData;
    logic [31:0] out_CommitCount;

    int checks = 0;
    int errors = 0;

    writeback_register_file dut (
        .clk               (clk),
        .reset             (reset),
        .in_PC_4           (in_PC_4),
        .in_MemoryData     (in_MemoryData),
        .in_ALUResult      (in_ALUResult),
        .in_WriteRegister  (in_WriteRegister),
        .in_CtrlRegWrite   (in_CtrlRegWrite),
        .in_CtrlALUOrMem   (in_CtrlALUOrMem),
        .in_CtrlALUMemOrPC (in_CtrlALUMemOrPC),
        .in_ReadRegister1  (in_ReadRegister1),
        .in_ReadRegister2  (in_ReadRegister2),
        .out_ReadData1     (out_ReadData1),
        .out_ReadData2     (out_ReadData2),
        .out_WriteBackData (out_WriteBackData),
        .out_CommitCount   (out_CommitCount)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic rw, input logic [4:0] wr, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4);
        in_CtrlRegWrite   = rw;
        in_WriteRegister  = wr;
        in_CtrlALUMemOrPC = sel[1];
        in_CtrlALUOrMem   = sel[0];
        in_ALUResult      = alu;
        in_MemoryData     = mem;
        in_PC_4           = pc4;
    endtask

    task automatic commit(input logic [4:0] wr, input logic [31:0] alu);
        @(negedge clk);
        drive(1'b1, wr, 2'b00, alu, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        in_CtrlRegWrite = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp1;
        logic [31:0] exp2;
        reset = 1'b0;
        drive(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
        #12;
        for (int i = 0; i < 32; i++) begin
            in_ReadRegister1 = 5'(i);
            in_ReadRegister2 = 5'(31 - i);
            #1;
            exp1 = (i == 28) ? 32'h1000_8000 : (i == 29) ? 32'h7FFF_EFFC : 32'h0;
            exp2 = ((31 - i) == 28) ? 32'h1000_8000 : ((31 - i) == 29) ? 32'h7FFF_EFFC : 32'h0;
            checks++;
            if (out_ReadData1 !== exp1) begin
                errors++;
                $display("FAIL reset_rd1[%0d]: got %h expected %h", i, out_ReadData1, exp1);
            end
            checks++;
            if (out_ReadData2 !== exp2) begin
                errors++;
                $display("FAIL reset_rd2[%0d]: got %h expected %h", 31 - i, out_ReadData2, exp2);
            end
        end
        checks++;
        if (out_CommitCount !== 32'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", out_CommitCount);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_source_select();
        logic [31:0] exp_tbl [4];
        exp_tbl[0] = 32'h0000_00A5;
        exp_tbl[1] = 32'h0000_005A;
        exp_tbl[2] = 32'h0040_0004;
        exp_tbl[3] = 32'h0040_0004;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b1, 5'd8, 2'(k), 32'hA5, 32'h5A, 32'h0040_0004);
            #1;
            checks++;
            if (out_WriteBackData !== exp_tbl[k]) begin
                errors++;
                $display("FAIL wb_sel[%0d]: got %h expected %h", k, out_WriteBackData, exp_tbl[k]);
            end
            @(posedge clk);
            @(negedge clk);
            in_CtrlRegWrite  = 1'b0;
            in_ReadRegister1 = 5'd8;
            #1;
            checks++;
            if (out_ReadData1 !== exp_tbl[k]) begin
                errors++;
                $display("FAIL reg8_sel[%0d]: got %h expected %h", k, out_ReadData1, exp_tbl[k]);
            end
        end
        checks++;
        if (out_CommitCount !== 32'd4) begin
            errors++;
            $display("FAIL select_count: got %0d expected 4", out_CommitCount);
        end
        // Unselected sources carrying X must stay masked
        drive(1'b0, 5'd8, 2'b00, 32'h0000_1111, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
        #1;
        checks++;
        if (out_WriteBackData !== 32'h0000_1111) begin
            errors++;
            $display("FAIL x_mask_alu: got %h expected 00001111", out_WriteBackData);
        end
        drive(1'b0, 5'd8, 2'b01, 32'hxxxx_xxxx, 32'h0000_2222, 32'hxxxx_xxxx);
        #1;
        checks++;
        if (out_WriteBackData !== 32'h0000_2222) begin
            errors++;
            $display("FAIL x_mask_mem: got %h expected 00002222", out_WriteBackData);
        end
        drive(1'b0, 5'd8, 2'b11, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 32'h0000_3333);
        #1;
        checks++;
        if (out_WriteBackData !== 32'h0000_3333) begin
            errors++;
            $display("FAIL x_mask_pc: got %h expected 00003333", out_WriteBackData);
        end
        drive(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_bypass();
        @(negedge clk);
        drive(1'b1, 5'd9, 2'b00, 32'h1234, 32'h0, 32'h0);
        in_ReadRegister1 = 5'd9;
        in_ReadRegister2 = 5'd9;
        #1;
        checks++;
        if (out_ReadData1 !== 32'h1234) begin
            errors++;
            $display("FAIL bypass_rd1: got %h expected 00001234", out_ReadData1);
        end
        checks++;
        if (out_ReadData2 !== 32'h1234) begin
            errors++;
            $display("FAIL bypass_rd2: got %h expected 00001234", out_ReadData2);
        end
        @(posedge clk);
        @(negedge clk);
        in_CtrlRegWrite = 1'b0;
        in_ALUResult    = 32'hDEAD_0000;
        #1;
        checks++;
        if (out_ReadData1 !== 32'h1234) begin
            errors++;
            $display("FAIL array_rd1: got %h expected 00001234", out_ReadData1);
        end
        checks++;
        if (out_ReadData2 !== 32'h1234) begin
            errors++;
            $display("FAIL array_rd2: got %h expected 00001234", out_ReadData2);
        end
        checks++;
        if (out_CommitCount !== 32'd5) begin
            errors++;
            $display("FAIL bypass_count: got %0d expected 5", out_CommitCount);
        end
    endtask

    task automatic test_zero();
        @(negedge clk);
        drive(1'b1, 5'd0, 2'b00, 32'hFFFF_FFFF, 32'h0, 32'h0);
        in_ReadRegister1 = 5'd0;
        in_ReadRegister2 = 5'd0;
        #1;
        checks++;
        if (out_ReadData1 !== 32'h0 || out_ReadData2 !== 32'h0) begin
            errors++;
            $display("FAIL zero_before: got %h/%h expected 0/0", out_ReadData1, out_ReadData2);
        end
        @(posedge clk);
        @(negedge clk);
        in_CtrlRegWrite = 1'b0;
        #1;
        checks++;
        if (out_ReadData1 !== 32'h0 || out_ReadData2 !== 32'h0) begin
            errors++;
            $display("FAIL zero_after: got %h/%h expected 0/0", out_ReadData1, out_ReadData2);
        end
        checks++;
        if (out_CommitCount !== 32'd5) begin
            errors++;
            $display("FAIL zero_count: got %0d expected 5", out_CommitCount);
        end
    endtask

    task automatic test_regwrite_off();
        @(negedge clk);
        drive(1'b0, 5'd10, 2'b00, 32'h77, 32'h0, 32'h0);
        in_ReadRegister1 = 5'd10;
        #1;
        checks++;
        if (out_ReadData1 !== 32'h0) begin
            errors++;
            $display("FAIL nowrite_bypass: got %h expected 0", out_ReadData1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_ReadData1 !== 32'h0) begin
            errors++;
            $display("FAIL nowrite_reg10: got %h expected 0", out_ReadData1);
        end
        checks++;
        if (out_CommitCount !== 32'd5) begin
            errors++;
            $display("FAIL nowrite_count: got %0d expected 5", out_CommitCount);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        commit(5'd5, 32'h11);
        commit(5'd6, 32'h22);
        commit(5'd5, 32'h55);
        in_ReadRegister1 = 5'd5;
        #1;
        checks++;
        if (out_ReadData1 !== 32'h55 || out_CommitCount !== 32'd3) begin
            errors++;
            $display("FAIL pre_reset: got reg5=%h count=%0d expected 55/3", out_ReadData1, out_CommitCount);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_ReadData1 !== 32'h0) begin
            errors++;
            $display("FAIL async_reg5: got %h expected 0", out_ReadData1);
        end
        checks++;
        if (out_CommitCount !== 32'd0) begin
            errors++;
            $display("FAIL async_count: got %0d expected 0", out_CommitCount);
        end
        @(negedge clk);
        drive(1'b1, 5'd5, 2'b00, 32'h99, 32'h0, 32'h0);
        #1;
        checks++;
        if (out_ReadData1 !== 32'h99) begin
            errors++;
            $display("FAIL reset_bypass: got %h expected 00000099", out_ReadData1);
        end
        @(posedge clk);
        @(negedge clk);
        in_CtrlRegWrite = 1'b0;
        #1;
        checks++;
        if (out_ReadData1 !== 32'h0 || out_CommitCount !== 32'd0) begin
            errors++;
            $display("FAIL held_reset: got reg5=%h count=%0d expected 0/0", out_ReadData1, out_CommitCount);
        end
        reset = 1'b1;
    endtask

    initial begin
        in_ReadRegister1 = 5'd0;
        in_ReadRegister2 = 5'd0;
        test_reset();
        test_source_select();
        test_bypass();
        test_zero();
        test_regwrite_off();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
